// File: rtl/spi_pkg.sv
// Shared constants, FSM state encoding and the sclk half-period lookup for the SPI master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

  localparam int DATA_W = 16;                   // frame length in bits
  localparam int CNT_W  = $clog2(DATA_W) + 1;   // bit counter, reaches DATA_W
  localparam int HALF_W = 5;                    // holds the largest half period (16)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Half sclk period in clk cycles: 00->2, 01->4, 10->8, 11->16.
  function automatic logic [HALF_W-1:0] half_of(input logic [1:0] freq_sel);
    return HALF_W'(2) << freq_sel;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter: emits a one-cycle tick every `half` clk cycles while enabled.
// Latency: first tick `half` cycles after en rises; counter clears whenever en is low.
// Backpressure: none; free-running while en=1.
//   clk   in  1       system clock
//   rst_n in  1       asynchronous active-low reset
//   en    in  1       count enable (low holds the counter at zero)
//   half  in  HALF_W  half period latched by the owner at frame start
//   tick  out 1       strobe marking the end of each half period
module spi_clk_gen
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [HALF_W-1:0] half,
  output logic              tick
);

  logic [HALF_W-1:0] cnt;

  assign tick = en && (cnt == half - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_slave.sv
// SPI mode-1 master: one 16-bit MSB-first full-duplex frame per start pulse, TX word staged separately.
// Latency: cs_bar low for 1 + H + 32*H + H cycles; rx_valid/tx_done pulse as cs_bar rises.
// Backpressure: slave_rx_start ignored while a frame is in flight; TX staging accepted at any time.
//   clk, reset                 clock and asynchronous active-low reset
//   slave_rx_start             start pulse; slave_tx_start + input_reg_data stage the next TX word
//   freq_control               sclk rate select, latched at frame start
//   cs_bar, sclk, din_mosi     SPI outputs; dout_miso is the SPI input
//   output_reg_data, rx_valid  received word and its one-cycle strobe; tx_done flags a staged word sent
module spi_master_slave
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              slave_rx_start,
  input  logic              slave_tx_start,
  input  logic [DATA_W-1:0] input_reg_data,
  input  logic              dout_miso,
  input  logic [1:0]        freq_control,
  output logic              cs_bar,
  output logic              sclk,
  output logic              din_mosi,
  output logic [DATA_W-1:0] output_reg_data,
  output logic              rx_valid,
  output logic              tx_done
);

  state_t            state, state_nxt;
  logic [HALF_W-1:0] half_q;
  logic [DATA_W-1:0] tx_buf, tx_sh, rx_sh;
  logic              tx_pend, frame_has_tx;
  logic [CNT_W-1:0]  bit_cnt;
  logic              arm;
  logic              tick, clk_en, start_ok, last_fall;

  // cs_bar falls one cycle before the half-period counter starts, so chip
  // select always leads the setup interval by a full clk cycle.
  assign clk_en    = (state != IDLE) && !arm;
  assign start_ok  = (state == IDLE) && slave_rx_start;
  assign last_fall = (state == XFER) && tick && sclk && (bit_cnt == CNT_W'(DATA_W - 1));

  spi_clk_gen u_clk_gen (
    .clk   (clk),
    .rst_n (reset),
    .en    (clk_en),
    .half  (half_q),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (slave_rx_start) state_nxt = SETUP;
      SETUP:   if (tick)           state_nxt = XFER;
      XFER:    if (last_fall)      state_nxt = DONE;
      DONE:    if (tick)           state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_bar          <= 1'b1;
      sclk            <= 1'b0;
      din_mosi        <= 1'b0;
      output_reg_data <= '0;
      rx_valid        <= 1'b0;
      tx_done         <= 1'b0;
      half_q          <= '0;
      tx_buf          <= '0;
      tx_pend         <= 1'b0;
      tx_sh           <= '0;
      rx_sh           <= '0;
      frame_has_tx    <= 1'b0;
      bit_cnt         <= '0;
      arm             <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_done  <= 1'b0;
      arm      <= 1'b0;

      if (slave_tx_start) begin
        tx_buf  <= input_reg_data;
        tx_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_ok) begin
            half_q       <= half_of(freq_control);
            tx_sh        <= tx_pend ? tx_buf : '0;
            frame_has_tx <= tx_pend;
            // A word presented in the start cycle belongs to the next frame.
            if (!slave_tx_start) tx_pend <= 1'b0;
            bit_cnt      <= '0;
            cs_bar       <= 1'b0;
            arm          <= 1'b1;
          end
        end
        XFER: begin
          // Each bit is a low half followed by a high half; mosi changes on
          // the rise, miso is captured on the fall.
          if (tick) begin
            if (!sclk) begin
              sclk     <= 1'b1;
              din_mosi <= tx_sh[DATA_W-1];
              tx_sh    <= {tx_sh[DATA_W-2:0], 1'b0};
            end else begin
              sclk     <= 1'b0;
              rx_sh    <= {rx_sh[DATA_W-2:0], dout_miso};
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (tick) begin
            cs_bar          <= 1'b1;
            din_mosi        <= 1'b0;
            output_reg_data <= rx_sh;
            rx_valid        <= 1'b1;
            tx_done         <= frame_has_tx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_slave.sv
// Directed bench for spi_master_slave: frames at several rates, staging, ignored restart, mid-frame reset.
// Latency: n/a.
// Backpressure: n/a.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errs++; \
      $error("FAIL %s: got 'h%0h expected 'h%0h", tag, (obs), (exp)); \
    end \
  end

module tb_spi_master_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        slave_rx_start, slave_tx_start;
  logic [15:0] input_reg_data;
  logic        dout_miso;
  logic [1:0]  freq_control;
  logic        cs_bar, sclk, din_mosi, rx_valid, tx_done;
  logic [15:0] output_reg_data;

  int errs   = 0;
  int checks = 0;

  // Frame monitor state, cleared whenever frame_id changes.
  int          frame_id = 0;
  int          seen_id  = 0;
  int          cyc = 0;
  int          rises, falls, cs_low_cyc, rxv_cnt, txd_cnt, both_cnt, sclk_bad;
  int          t_rise0, t_rise1;
  logic [15:0] mosi_word;
  logic [15:0] miso_word;
  logic        sclk_prev = 1'b0;

  always #5 clk = ~clk;

  spi_master_slave dut (
    .clk             (clk),
    .reset           (rst_n),
    .slave_rx_start  (slave_rx_start),
    .slave_tx_start  (slave_tx_start),
    .input_reg_data  (input_reg_data),
    .dout_miso       (dout_miso),
    .freq_control    (freq_control),
    .cs_bar          (cs_bar),
    .sclk            (sclk),
    .din_mosi        (din_mosi),
    .output_reg_data (output_reg_data),
    .rx_valid        (rx_valid),
    .tx_done         (tx_done)
  );

  // Peripheral model: records mosi on each sclk rise and presents the next
  // miso bit right after it, so the DUT sees it stable at the falling edge.
  initial begin
    dout_miso = 1'b0;
    sclk_bad  = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (frame_id != seen_id) begin
        seen_id = frame_id;
        rises = 0; falls = 0; cs_low_cyc = 0; rxv_cnt = 0; txd_cnt = 0; both_cnt = 0;
        t_rise0 = 0; t_rise1 = 0; mosi_word = '0;
      end
      if (!cs_bar) cs_low_cyc++;
      if (cs_bar && sclk) sclk_bad++;
      if (sclk && !sclk_prev) begin
        if (rises == 0) t_rise0 = cyc;
        if (rises == 1) t_rise1 = cyc;
        mosi_word = {mosi_word[14:0], din_mosi};
        if (rises < 16) dout_miso = miso_word[4'(15 - rises)];
        rises++;
      end
      if (!sclk && sclk_prev) falls++;
      if (rx_valid) rxv_cnt++;
      if (tx_done) txd_cnt++;
      if (rx_valid && tx_done) both_cnt++;
      sclk_prev = sclk;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic stage(input logic [15:0] w);
    @(negedge clk);
    slave_tx_start = 1'b1;
    input_reg_data = w;
    @(negedge clk);
    slave_tx_start = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] miso);
    miso_word = miso;
    frame_id++;
    @(negedge clk);
    slave_rx_start = 1'b1;
    @(negedge clk);
    slave_rx_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (cs_bar !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    `CHK(tag, n < 1000, 1'b1)
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    slave_rx_start = 1'b0;
    slave_tx_start = 1'b0;
    input_reg_data = '0;
    freq_control   = 2'b11;
    miso_word      = '0;
    repeat (3) @(negedge clk);

    // Reset state
    `CHK("rst_cs_bar", cs_bar, 1'b1)
    `CHK("rst_sclk", sclk, 1'b0)
    `CHK("rst_mosi", din_mosi, 1'b0)
    `CHK("rst_rdata", output_reg_data, 16'h0000)
    `CHK("rst_rx_valid", rx_valid, 1'b0)
    `CHK("rst_tx_done", tx_done, 1'b0)
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: H=16, staged 0xF1F1
    stage(16'hF1F1);
    start_frame(16'h0000);
    wait_done("t1_timeout");
    `CHK("t1_mosi", mosi_word, 16'hF1F1)
    `CHK("t1_rises", rises, 16)
    `CHK("t1_falls", falls, 16)
    `CHK("t1_period", t_rise1 - t_rise0, 32)
    `CHK("t1_cs_low", cs_low_cyc, 1 + 16 + 512 + 16)
    `CHK("t1_rx_valid", rxv_cnt, 1)
    `CHK("t1_tx_done", txd_cnt, 1)
    `CHK("t1_together", both_cnt, 1)
    `CHK("t1_mosi_idle", din_mosi, 1'b0)

    // T2: H=4, nothing staged, miso 0x0001
    freq_control = 2'b01;
    start_frame(16'h0001);
    wait_done("t2_timeout");
    `CHK("t2_rdata", output_reg_data, 16'h0001)
    `CHK("t2_rx_valid", rxv_cnt, 1)
    `CHK("t2_tx_done", txd_cnt, 0)
    `CHK("t2_mosi", mosi_word, 16'h0000)
    `CHK("t2_period", t_rise1 - t_rise0, 8)

    // T3: H=2, miso 0xA5C3
    freq_control = 2'b00;
    start_frame(16'hA5C3);
    wait_done("t3_timeout");
    `CHK("t3_rdata", output_reg_data, 16'hA5C3)
    `CHK("t3_period", t_rise1 - t_rise0, 4)
    `CHK("t3_cs_low", cs_low_cyc, 69)
    `CHK("t3_rx_valid", rxv_cnt, 1)

    // T4: restart mid-frame ignored; freq_control change mid-frame ignored
    start_frame(16'h3C5A);
    repeat (20) @(negedge clk);
    freq_control   = 2'b11;
    slave_rx_start = 1'b1;
    @(negedge clk);
    slave_rx_start = 1'b0;
    wait_done("t4_timeout");
    `CHK("t4_rises", rises, 16)
    `CHK("t4_rx_valid", rxv_cnt, 1)
    `CHK("t4_rdata", output_reg_data, 16'h3C5A)
    `CHK("t4_cs_low", cs_low_cyc, 69)
    freq_control = 2'b00;

    // T5: reset after 5th rise, with a word staged mid-frame that reset must discard
    start_frame(16'hFFFF);
    stage(16'hBEEF);
    begin
      int n = 0;
      while (rises < 5 && n < 200) begin
        @(negedge clk);
        n++;
      end
      `CHK("t5_wait_rise", n < 200, 1'b1)
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    `CHK("t5_cs_bar", cs_bar, 1'b1)
    `CHK("t5_sclk", sclk, 1'b0)
    `CHK("t5_mosi", din_mosi, 1'b0)
    `CHK("t5_rdata", output_reg_data, 16'h0000)
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    `CHK("t5_no_rxv", rxv_cnt, 0)
    `CHK("t5_no_txd", txd_cnt, 0)
    start_frame(16'h00FF);
    wait_done("t5b_timeout");
    `CHK("t5_rdata_after", output_reg_data, 16'h00FF)
    `CHK("t5_mosi_after", mosi_word, 16'h0000)
    `CHK("t5_txd_after", txd_cnt, 0)

    // T6: staging during a busy frame only affects the next frame
    stage(16'hAAAA);
    start_frame(16'h1111);
    repeat (20) @(negedge clk);
    stage(16'h1234);
    wait_done("t6_timeout");
    `CHK("t6_mosi_cur", mosi_word, 16'hAAAA)
    `CHK("t6_txd_cur", txd_cnt, 1)
    start_frame(16'h2222);
    wait_done("t6b_timeout");
    `CHK("t6_mosi_next", mosi_word, 16'h1234)
    `CHK("t6_txd_next", txd_cnt, 1)
    `CHK("t6_rdata_next", output_reg_data, 16'h2222)

    // T7: stage and start in the same idle cycle -> word waits for the next frame
    miso_word = 16'h0F0F;
    frame_id++;
    @(negedge clk);
    slave_rx_start = 1'b1;
    slave_tx_start = 1'b1;
    input_reg_data = 16'h5555;
    @(negedge clk);
    slave_rx_start = 1'b0;
    slave_tx_start = 1'b0;
    wait_done("t7_timeout");
    `CHK("t7_mosi_cur", mosi_word, 16'h0000)
    `CHK("t7_txd_cur", txd_cnt, 0)
    start_frame(16'h0000);
    wait_done("t7b_timeout");
    `CHK("t7_mosi_next", mosi_word, 16'h5555)
    `CHK("t7_txd_next", txd_cnt, 1)

    `CHK("sclk_while_cs_high", sclk_bad, 0)

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
